// File: rtl/psec6_readout_sequencer.sv
// Readout sequencer: walks every enabled PSEC6 channel through all registers,
// deserialises CNT_SER and hands each word to the SPI transmit side.
module psec6_readout_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int WORD_BITS     = 10,
    parameter int NUM_REGS      = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              SPI_CLK,
    input  logic              RSTB,
    input  logic              START,
    input  logic [NUM_CH-1:0] CH_MASK,
    input  logic [NUM_CH-1:0] CNT_SER,
    output logic [NUM_CH-1:0] INST_READOUT,
    output logic [2:0]        SELECT_REG,
    output logic [15:0]       WORD_DATA,
    output logic              WORD_VALID,
    input  logic              WORD_READY,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > WORD_BITS) ? SETTLE_CYCLES : WORD_BITS;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LOAD,
        S_SHIFT,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t               state, state_next;
    logic [NUM_CH-1:0]    pend_mask;
    logic [CH_W-1:0]      ch_idx;
    logic [CH_W-1:0]      low_idx;
    logic [REG_W-1:0]     reg_idx;
    logic [CNT_W-1:0]     cnt;
    logic [WORD_BITS-1:0] shreg;
    logic                 last_reg;

    assign last_reg = (reg_idx == REG_W'(NUM_REGS - 1));

    // Lowest pending channel wins, so channels are serviced in ascending order.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_mask[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    // State register and datapath.
    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= S_IDLE;
            pend_mask <= '0;
            ch_idx    <= '0;
            reg_idx   <= '0;
            cnt       <= '0;
            shreg     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples the pre-edge values of its neighbours.
            state <= state_next;

            if (state_next != state) begin
                cnt <= '0;
            end else if (state == S_LOAD || state == S_SHIFT) begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        pend_mask <= CH_MASK;
                    end
                end
                S_SCAN: begin
                    if (pend_mask != '0) begin
                        ch_idx  <= low_idx;
                        reg_idx <= '0;
                    end
                end
                S_SHIFT: begin
                    shreg <= {shreg[WORD_BITS-2:0], CNT_SER[ch_idx]};
                end
                S_EMIT: begin
                    if (WORD_READY) begin
                        if (last_reg) begin
                            pend_mask[ch_idx] <= 1'b0;
                        end else begin
                            reg_idx <= reg_idx + REG_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting every output of a combinational block first means
        // no path leaves it unassigned, so no latch can be inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (START) state_next = S_SCAN;
            end
            S_SCAN: begin
                state_next = (pend_mask == '0) ? S_FINISH : S_LOAD;
            end
            S_LOAD: begin
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == CNT_W'(WORD_BITS - 1)) state_next = S_EMIT;
            end
            S_EMIT: begin
                if (WORD_READY) state_next = last_reg ? S_SCAN : S_LOAD;
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from state only; SCAN drops INST_READOUT between channels.
    always_comb begin
        INST_READOUT = '0;
        SELECT_REG   = '0;
        WORD_DATA    = '0;
        WORD_VALID   = 1'b0;
        BUSY         = (state != S_IDLE);
        DONE         = (state == S_FINISH);
        case (state)
            S_LOAD, S_SHIFT: begin
                INST_READOUT = NUM_CH'(1) << ch_idx;
                SELECT_REG   = 3'(reg_idx);
            end
            S_EMIT: begin
                INST_READOUT = NUM_CH'(1) << ch_idx;
                SELECT_REG   = 3'(reg_idx);
                WORD_VALID   = 1'b1;
                WORD_DATA    = 16'({3'(ch_idx), 3'(reg_idx), shreg});
            end
            default: ;
        endcase
    end

    a_inst_onehot0 : assert property (@(posedge SPI_CLK) disable iff (!RSTB)
        $onehot0(INST_READOUT));

    a_word_hold : assert property (@(posedge SPI_CLK) disable iff (!RSTB)
        (WORD_VALID && !WORD_READY) |=> (WORD_VALID && $stable(WORD_DATA)));

endmodule

// File: tb/tb_psec6_readout_sequencer.sv
// Scoreboard bench for psec6_readout_sequencer: a channel model streams CNT_SER,
// a monitor pops expected words on every handshake and checks invariants.
`timescale 1ns/1ps
module tb_psec6_readout_sequencer;

    localparam int NUM_CH        = 8;
    localparam int WORD_BITS     = 10;
    localparam int NUM_REGS      = 6;
    localparam int SETTLE_CYCLES = 2;

    logic              spi_clk = 1'b0;
    logic              rstb    = 1'b0;
    logic              start   = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [NUM_CH-1:0] cnt_ser = '1;
    logic [NUM_CH-1:0] inst_readout;
    logic [2:0]        select_reg;
    logic [15:0]       word_data;
    logic              word_valid;
    logic              word_ready = 1'b1;
    logic              busy;
    logic              done;

    psec6_readout_sequencer #(
        .NUM_CH(NUM_CH), .WORD_BITS(WORD_BITS),
        .NUM_REGS(NUM_REGS), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .SPI_CLK(spi_clk), .RSTB(rstb), .START(start), .CH_MASK(ch_mask),
        .CNT_SER(cnt_ser), .INST_READOUT(inst_readout), .SELECT_REG(select_reg),
        .WORD_DATA(word_data), .WORD_VALID(word_valid), .WORD_READY(word_ready),
        .BUSY(busy), .DONE(done)
    );

    always #12.5 spi_clk = ~spi_clk;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          t0       = 0;
    int          w0       = 0;
    int          word_cnt = 0;
    int          pat_mode = 0;
    logic [15:0] sb[$];

    always @(posedge spi_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pat(input int ch, input int rg);
        logic [9:0] v;
        case (pat_mode)
            0:       v = 10'h2A5;
            1:       v = 10'h3FF >> ch;
            default: v = 10'(ch * 67 + rg * 13 + 5) ^ 10'h155;
        endcase
        return v;
    endfunction

    // Channel model: a fresh INST_READOUT/SELECT_REG combination restarts the
    // stream; after the settle window the word is presented MSB first.
    logic [15:0] cm_key_prev = '0;
    logic [15:0] cm_key;
    logic [9:0]  cm_w;
    int          cm_k = 0;
    int          cm_bi;
    always @(negedge spi_clk) begin
        cm_key = {inst_readout, 5'b0, select_reg};
        if (cm_key != cm_key_prev) cm_k = 0;
        else cm_k++;
        cm_key_prev = cm_key;
        cm_bi = cm_k - SETTLE_CYCLES;
        for (int c = 0; c < NUM_CH; c++) begin
            cm_w = pat(c, int'(select_reg));
            if (cm_bi < 0)               cnt_ser[c] = ~cm_w[WORD_BITS-1];
            else if (cm_bi >= WORD_BITS) cnt_ser[c] = ~cm_w[0];
            else                         cnt_ser[c] = cm_w[WORD_BITS-1-cm_bi];
        end
    end

    // Monitor: pops the scoreboard on every handshake and watches the invariants.
    logic              stall_seen = 1'b0;
    logic [15:0]       stall_data = '0;
    logic [15:0]       exp_word;
    logic [NUM_CH-1:0] last_inst  = '0;
    logic              seen_ch    = 1'b0;
    int                zrun       = 0;
    always @(negedge spi_clk) begin
        if (!rstb) begin
            stall_seen = 1'b0;
            seen_ch    = 1'b0;
            zrun       = 0;
        end else begin
            if (busy) begin
                check("inst_onehot0", 32'($onehot0(inst_readout)), 32'd1);
                if (inst_readout == '0) begin
                    zrun++;
                end else begin
                    if (seen_ch && inst_readout != last_inst) check("inst_gap", zrun, 1);
                    zrun      = 0;
                    seen_ch   = 1'b1;
                    last_inst = inst_readout;
                end
            end else begin
                zrun    = 0;
                seen_ch = 1'b0;
            end

            if (word_valid) begin
                check("inst_matches_word", inst_readout, NUM_CH'(1) << word_data[15:13]);
                check("select_matches_word", select_reg, word_data[12:10]);
                if (stall_seen) check("stall_hold", word_data, stall_data);
                if (word_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", word_data);
                    end else begin
                        exp_word = sb.pop_front();
                        check("word", word_data, exp_word);
                    end
                    word_cnt++;
                    stall_seen = 1'b0;
                end else begin
                    stall_seen = 1'b1;
                    stall_data = word_data;
                end
            end else if (stall_seen) begin
                check("valid_held", word_valid, 1);
                stall_seen = 1'b0;
            end
        end
    end

    task automatic start_pass(input logic [NUM_CH-1:0] m);
        for (int c = 0; c < NUM_CH; c++) begin
            if (m[c]) begin
                for (int r = 0; r < NUM_REGS; r++) sb.push_back({3'(c), 3'(r), pat(c, r)});
            end
        end
        w0 = word_cnt;
        @(posedge spi_clk); #1;
        start   = 1'b1;
        ch_mask = m;
        @(posedge spi_clk); #1;
        start = 1'b0;
        t0    = cyc - 1;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input string name, input int exp_lat, input int exp_words);
        while (!done && (cyc - t0) < exp_lat + 300) begin
            @(posedge spi_clk); #1;
        end
        check({name, "_done"}, done, 1);
        check({name, "_latency"}, cyc - t0, exp_lat);
        check({name, "_words"}, word_cnt - w0, exp_words);
        check({name, "_sb_empty"}, sb.size(), 0);
        @(posedge spi_clk); #1;
        check({name, "_busy_low"}, busy, 0);
        check({name, "_done_pulse"}, done, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_inst"}, inst_readout, 0);
        check({name, "_select"}, select_reg, 0);
        check({name, "_data"}, word_data, 0);
        check({name, "_valid"}, word_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
    endtask

    initial begin
        int n;
        rstb = 1'b0;
        repeat (3) @(posedge spi_clk);
        #1;
        check_all_zero("reset");
        rstb = 1'b1;

        // Single channel, constant pattern: 6 words 02A5, 06A5 ... 16A5.
        pat_mode = 0;
        start_pass(8'h01);
        wait_done("ch0", 81, 6);

        // Sparse mask; CH_MASK changes mid-pass must not matter.
        pat_mode = 2;
        start_pass(8'b1010_0100);
        repeat (40) begin @(posedge spi_clk); #1; end
        ch_mask = 8'hFF;
        wait_done("mask_a4", 239, 18);

        // Backpressure on the third word for 20 cycles.
        pat_mode = 0;
        start_pass(8'h01);
        n = 0;
        while (word_cnt < w0 + 2 && n < 100) begin @(posedge spi_clk); #1; n++; end
        check("stall_reach_word2", 32'(word_cnt - w0), 32'd2);
        word_ready = 1'b0;
        n = 0;
        while (!word_valid && n < 100) begin @(posedge spi_clk); #1; n++; end
        check("stall_word3_valid", word_valid, 1);
        repeat (20) begin @(posedge spi_clk); #1; end
        check("stall_still_valid", word_valid, 1);
        check("stall_select_held", select_reg, 3'd2);
        word_ready = 1'b1;
        wait_done("stall", 101, 6);

        // Empty mask finishes two cycles after START.
        start_pass(8'h00);
        wait_done("empty", 2, 0);

        // A second START during a pass is ignored.
        pat_mode = 1;
        start_pass(8'h01);
        repeat (30) begin @(posedge spi_clk); #1; end
        start   = 1'b1;
        ch_mask = 8'hFF;
        @(posedge spi_clk); #1;
        start = 1'b0;
        wait_done("restart_ignored", 81, 6);

        // Asynchronous reset in the middle of SHIFT for ch3 reg2.
        pat_mode = 2;
        start_pass(8'h08);
        n = 0;
        while (select_reg != 3'd2 && n < 200) begin @(posedge spi_clk); #1; n++; end
        check("abort_reach_reg2", select_reg, 3'd2);
        check("abort_inst_ch3", inst_readout, 8'h08);
        repeat (4) @(posedge spi_clk);
        #5;
        rstb = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        @(posedge spi_clk); #1;
        check_all_zero("abort_held");
        rstb = 1'b1;
        start_pass(8'h08);
        wait_done("after_abort", 81, 6);

        // All channels, distinct per-channel patterns.
        pat_mode = 1;
        start_pass(8'hFF);
        wait_done("all_ch", 634, 48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psec6_readout_sequencer.md
Name: psec6_readout_sequencer

Overview:
- Chip-level SPI-domain controller that sequences readout of every PSEC6 channel's timestamp/trigger-count registers.
- For each enabled channel it does the following:
  - asserts that channel's INST_READOUT;
  - steps SELECT_REG through all registers;
  - deserialises the channel's CNT_SER stream into parallel words;
  - hands each word to the SPI transmit logic over a valid/ready handshake.
- It replaces firmware bit-banging of INST_READOUT/SELECT_REG and guarantees only one channel drives the readout mux at a time.

Parameters:
- NUM_CH, 8, number of channels sequenced (CH_IDX width = 3 at default).
- WORD_BITS, 10, bits shifted per register (trigger_cnt is zero-padded to this width by the channel).
- NUM_REGS, 6, registers per channel; SELECT_REG 0 = trigger_cnt, 1..5 = CA..CE.
- SETTLE_CYCLES, 2, SPI_CLK cycles between SELECT_REG change and first sampled bit (mux settle).

Ports:
- SPI_CLK  in  1  40 MHz SPI clock; all logic on rising edge.
- RSTB  in  1  reset, asynchronous, active-low.
- START  in  1  single-cycle request to begin a full readout pass.
- CH_MASK  in  NUM_CH  channel enable mask, sampled only on an accepted START.
- CNT_SER  in  NUM_CH  serial data from each channel's readout shifter.
- INST_READOUT  out  NUM_CH  one-hot (or zero) readout enable per channel.
- SELECT_REG  out  3  register select broadcast to all channels.
- WORD_DATA  out  16  {ch_idx[2:0], reg_idx[2:0], data[9:0]}.
- WORD_VALID  out  1  WORD_DATA valid.
- WORD_READY  in  1  consumer accepts the word when high with WORD_VALID.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (RSTB low, asynchronous):
  - state IDLE;
  - INST_READOUT=0, SELECT_REG=0, WORD_DATA=0, WORD_VALID=0, BUSY=0, DONE=0;
  - internal mask, shift register, bit counter and reg counter cleared.
  - Reset mid-pass aborts immediately; there is no resume.
- States: IDLE, SCAN, LOAD, SHIFT, EMIT, FINISH.
- IDLE:
  - START=1 latches CH_MASK into pend_mask and moves to SCAN.
  - START in any other state is ignored.
- SCAN (1 cycle):
  - If pend_mask==0, go to FINISH.
  - Otherwise ch_idx := lowest set bit of pend_mask, reg_idx := 0, go to LOAD.
- LOAD (SETTLE_CYCLES cycles):
  - INST_READOUT[ch_idx]=1, all other bits 0.
  - SELECT_REG=reg_idx.
  - No sampling.
- SHIFT (WORD_BITS cycles):
  - Each rising edge shifts CNT_SER[ch_idx] in MSB-first: data = {data[WORD_BITS-2:0], bit}.
  - INST_READOUT and SELECT_REG are held.
- EMIT:
  - WORD_VALID=1, WORD_DATA={ch_idx, reg_idx, data}, held stable until WORD_READY=1.
  - On handshake, WORD_VALID drops the next cycle. Then:
    - if reg_idx<NUM_REGS-1: reg_idx++, go to LOAD (INST_READOUT stays high, SELECT_REG updates);
    - else: clear pend_mask[ch_idx], INST_READOUT:=0, go to SCAN.
  - No bits are sampled while stalled; backpressure is unlimited.
- FINISH (1 cycle): DONE=1, BUSY=0 next cycle, return to IDLE.
- Timing:
  - No-stall word period = SETTLE_CYCLES+WORD_BITS+1 = 13 cycles.
  - Per-channel overhead is 1 SCAN cycle.
  - Full pass, k channels, no stall = 13·NUM_REGS·k + k + 2 cycles from START to DONE (k=1 → 81).
- Invariants:
  - INST_READOUT is never multi-hot.
  - INST_READOUT goes low for at least the 1 SCAN cycle between channels (fresh channel load).
  - CH_MASK changes during BUSY have no effect.
  - CH_MASK=0: START → SCAN → FINISH, so DONE is asserted 2 cycles after START with no words and no INST_READOUT.

Test Plan:
- Reset, then START with CH_MASK=8'h01, CNT_SER[0] streaming 10'h2A5 for every register → 6 words 16'h02A5, 16'h06A5 … 16'h16A5; DONE 81 cycles after START; INST_READOUT=8'h01 only.
- CH_MASK=8'b1010_0100 → words only for ch 2, 5, 7 in that order; INST_READOUT low for exactly 1 cycle between channels; 18 words total.
- WORD_READY held low 20 cycles on the 3rd word → WORD_VALID/WORD_DATA stable throughout; next word's SHIFT does not begin until the handshake; data intact.
- CH_MASK=0 → DONE 2 cycles after START, no WORD_VALID; a second START during BUSY of a normal pass is ignored (word count unchanged).
- RSTB asserted during SHIFT of ch 3 reg 2 → all outputs 0 asynchronously; a new START afterwards produces a full clean pass starting at reg 0.
- Per-channel distinct patterns (ch_n sends 10'h3FF>>n) on CH_MASK=8'hFF → 48 words, ch_idx/reg_idx fields correct, no cross-channel bit leakage.
